// File: rtl/branch_unit.sv
// Branch execution unit: resolves direction/target for b, bc, bclr, bcctr, bctar and owns LR/CTR/TAR.
// Define BRANCH_TAR_EN to include the TAR register and bctar; otherwise bctar is illegal and o_tar reads 0.
module branch_unit #(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [31:0]     i_instr,
  input  logic            i_i_form,
  input  logic            i_b_form,
  input  logic            i_cond_LR,
  input  logic            i_cond_CTR,
  input  logic            i_cond_TAR,
  input  logic [XLEN-1:0] i_cia,
  input  logic [31:0]     i_cr,
  input  logic            i_spr_we,
  input  logic [1:0]      i_spr_sel,
  input  logic [XLEN-1:0] i_spr_wdata,
  output logic            o_ready,
  output logic            o_valid,
  output logic            o_taken,
  output logic            o_illegal,
  output logic [XLEN-1:0] o_nia,
  output logic [XLEN-1:0] o_lr,
  output logic [XLEN-1:0] o_ctr,
  output logic [XLEN-1:0] o_tar
);
  localparam logic [XLEN-1:0] ZERO_C = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONE_C  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] FOUR_C = {{(XLEN-3){1'b0}}, 3'd4};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EXEC = 1'b1} state_t;

  state_t            state_r, state_next_s;
  logic              ready_s, accept_s, exec_s;
  logic [25:0]       instr_r;
  logic [4:0]        flags_r;
  logic [XLEN-1:0]   cia_r;
  logic [31:0]       cr_r;
  logic              valid_r, taken_r, illegal_r;
  logic [XLEN-1:0]   nia_r, lr_r, ctr_r, tar_val_s;
  logic [4:0]        bo_s, bi_s;
  logic              cr_bit_s, ctr_ok_s, cond_ok_s;
  logic              taken_s, illegal_s, lr_upd_s, ctr_upd_s;
  logic [XLEN-1:0]   disp_i_s, disp_b_s, cia_plus4_s, ctr_cand_s, target_s, nia_s;

  assign accept_s = i_en & ready_s;
  assign exec_s   = (state_r == ST_EXEC);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // Next-state logic: EXEC always lasts exactly one cycle
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: state_next_s = accept_s ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      ST_IDLE: ready_s = 1'b1;
      ST_EXEC: ready_s = 1'b0;
      default: ready_s = 1'b0;
    endcase
  end

  // Operand capture on accept
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instr_r <= 26'd0;
      flags_r <= 5'd0;
      cia_r   <= ZERO_C;
      cr_r    <= 32'd0;
    end else if (accept_s) begin
      instr_r <= i_instr[25:0];
      flags_r <= {i_i_form, i_b_form, i_cond_LR, i_cond_CTR, i_cond_TAR};
      cia_r   <= i_cia;
      cr_r    <= i_cr;
    end else begin
      instr_r <= instr_r;
      flags_r <= flags_r;
      cia_r   <= cia_r;
      cr_r    <= cr_r;
    end
  end

  // BO is stored MSB-first, so Power bit BO_n lives at bo_s[4-n]
  assign bo_s        = instr_r[25:21];
  assign bi_s        = instr_r[20:16];
  assign cr_bit_s    = cr_r[5'd31 - bi_s];
  assign disp_i_s    = {{(XLEN-26){instr_r[25]}}, instr_r[25:2], 2'b00};
  assign disp_b_s    = {{(XLEN-16){instr_r[15]}}, instr_r[15:2], 2'b00};
  assign cia_plus4_s = cia_r + FOUR_C;
  assign ctr_cand_s  = bo_s[2] ? ctr_r : (ctr_r - ONE_C);
  assign ctr_ok_s    = bo_s[2] | ((ctr_cand_s != ZERO_C) ^ bo_s[1]);
  assign cond_ok_s   = bo_s[4] | (cr_bit_s == bo_s[3]);

  // Direction, target and register-update resolution
  always_comb begin
    taken_s   = 1'b0;
    target_s  = ZERO_C;
    illegal_s = !$onehot(flags_r) | (flags_r[1] & !bo_s[2]);
`ifndef BRANCH_TAR_EN
    illegal_s = illegal_s | flags_r[0];
`endif
    if (illegal_s) begin
      taken_s  = 1'b0;
      target_s = ZERO_C;
    end else if (flags_r[4]) begin
      taken_s  = 1'b1;
      target_s = instr_r[1] ? disp_i_s : (cia_r + disp_i_s);
    end else if (flags_r[3]) begin
      taken_s  = ctr_ok_s & cond_ok_s;
      target_s = instr_r[1] ? disp_b_s : (cia_r + disp_b_s);
    end else if (flags_r[2]) begin
      taken_s  = ctr_ok_s & cond_ok_s;
      target_s = {lr_r[XLEN-1:2], 2'b00};
    end else if (flags_r[1]) begin
      taken_s  = cond_ok_s;
      target_s = {ctr_r[XLEN-1:2], 2'b00};
    end else begin
      taken_s  = ctr_ok_s & cond_ok_s;
      target_s = {tar_val_s[XLEN-1:2], 2'b00};
    end
    nia_s     = taken_s ? target_s : cia_plus4_s;
    lr_upd_s  = !illegal_s & instr_r[0];
    ctr_upd_s = !illegal_s & !flags_r[4] & !bo_s[2];
  end

  // Result registers; o_valid pulses for the single cycle after EXEC
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_r   <= 1'b0;
      taken_r   <= 1'b0;
      illegal_r <= 1'b0;
      nia_r     <= ZERO_C;
    end else if (exec_s) begin
      valid_r   <= 1'b1;
      taken_r   <= taken_s;
      illegal_r <= illegal_s;
      nia_r     <= nia_s;
    end else begin
      valid_r   <= 1'b0;
      taken_r   <= taken_r;
      illegal_r <= illegal_r;
      nia_r     <= nia_r;
    end
  end

  // LR and CTR: a branch update beats a same-cycle SPR write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lr_r  <= ZERO_C;
      ctr_r <= ZERO_C;
    end else begin
      if (exec_s && lr_upd_s)                      lr_r <= cia_plus4_s;
      else if (i_spr_we && (i_spr_sel == 2'd0))    lr_r <= i_spr_wdata;
      else                                          lr_r <= lr_r;
      if (exec_s && ctr_upd_s)                     ctr_r <= ctr_cand_s;
      else if (i_spr_we && (i_spr_sel == 2'd1))    ctr_r <= i_spr_wdata;
      else                                          ctr_r <= ctr_r;
    end
  end

`ifdef BRANCH_TAR_EN
  logic [XLEN-1:0] tar_r;
  // TAR is only ever written through the SPR port
  always_ff @(posedge i_clk) begin
    if (i_rst)                                   tar_r <= ZERO_C;
    else if (i_spr_we && (i_spr_sel == 2'd2))    tar_r <= i_spr_wdata;
    else                                          tar_r <= tar_r;
  end
  assign tar_val_s = tar_r;
`else
  assign tar_val_s = ZERO_C;
`endif

  assign o_ready   = ready_s;
  assign o_valid   = valid_r;
  assign o_taken   = taken_r;
  assign o_illegal = illegal_r;
  assign o_nia     = nia_r;
  assign o_lr      = lr_r;
  assign o_ctr     = ctr_r;
  assign o_tar     = tar_val_s;
endmodule

// File: tb/tb_branch_unit.sv
// Directed, table-driven bench for branch_unit plus hand sequences for reset/SPR-collision corners.
module tb_branch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        f_i = 1'b0, f_b = 1'b0, f_lr = 1'b0, f_ctr = 1'b0, f_tar = 1'b0;
  logic [63:0] cia = 64'd0;
  logic [31:0] cr = 32'd0;
  logic        spr_we = 1'b0;
  logic [1:0]  spr_sel = 2'd0;
  logic [63:0] spr_wdata = 64'd0;
  logic        ready, valid, taken, illegal;
  logic [63:0] nia, lr, ctr, tar;

  int n_checks = 0;
  int n_errors = 0;

  branch_unit dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_instr(instr),
    .i_i_form(f_i), .i_b_form(f_b), .i_cond_LR(f_lr), .i_cond_CTR(f_ctr), .i_cond_TAR(f_tar),
    .i_cia(cia), .i_cr(cr), .i_spr_we(spr_we), .i_spr_sel(spr_sel), .i_spr_wdata(spr_wdata),
    .o_ready(ready), .o_valid(valid), .o_taken(taken), .o_illegal(illegal),
    .o_nia(nia), .o_lr(lr), .o_ctr(ctr), .o_tar(tar)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  flags;   // {I, B, LR, CTR, TAR}
    logic [63:0] cia;
    logic [31:0] cr;
    logic [63:0] pre_lr;
    logic [63:0] pre_ctr;
    logic        exp_taken;
    logic        exp_illegal;
    logic [63:0] exp_nia;
    logic [63:0] exp_lr;
    logic [63:0] exp_ctr;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spr_write(input logic [1:0] sel, input logic [63:0] data);
    @(negedge clk);
    spr_we = 1'b1; spr_sel = sel; spr_wdata = data;
    @(posedge clk);
    @(negedge clk);
    spr_we = 1'b0;
  endtask

  // Leaves the caller at the negedge inside the EXEC cycle
  task automatic start(input logic [31:0] ins, input logic [4:0] fl,
                       input logic [63:0] c, input logic [31:0] crv);
    int waited = 0;
    @(negedge clk);
    while (!ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) check("ready_timeout", 64'(ready), 64'd1);
    en = 1'b1; instr = ins; {f_i, f_b, f_lr, f_ctr, f_tar} = fl; cia = c; cr = crv;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'h48000100, 5'b10000, 64'h1000, 32'h0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h1100, 64'h0, 64'h0};
    vecs[1]  = '{32'h48000103, 5'b10000, 64'h2000, 32'h0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h100, 64'h2004, 64'h0};
    vecs[2]  = '{32'h4200FFF8, 5'b01000, 64'h2000, 32'h0, 64'h0, 64'h2, 1'b1, 1'b0, 64'h1FF8, 64'h0, 64'h1};
    vecs[3]  = '{32'h4200FFF8, 5'b01000, 64'h2000, 32'h0, 64'h0, 64'h1, 1'b0, 1'b0, 64'h2004, 64'h0, 64'h0};
    vecs[4]  = '{32'h4E800021, 5'b00100, 64'h500, 32'h0, 64'h3000, 64'h0, 1'b1, 1'b0, 64'h3000, 64'h504, 64'h0};
    vecs[5]  = '{32'h41820040, 5'b01000, 64'h0, 32'h20000000, 64'h0, 64'h0, 1'b1, 1'b0, 64'h40, 64'h0, 64'h0};
    vecs[6]  = '{32'h41820040, 5'b01000, 64'h0, 32'h0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h4, 64'h0, 64'h0};
    vecs[7]  = '{32'h48000101, 5'b11000, 64'h1000, 32'h0, 64'h77, 64'h9, 1'b0, 1'b1, 64'h1004, 64'h77, 64'h9};
    vecs[8]  = '{32'h4C000420, 5'b00010, 64'h600, 32'h0, 64'h55, 64'h100, 1'b0, 1'b1, 64'h604, 64'h55, 64'h100};
    vecs[9]  = '{32'h48000100, 5'b00000, 64'h700, 32'h0, 64'h11, 64'h22, 1'b0, 1'b1, 64'h704, 64'h11, 64'h22};
    vecs[10] = '{32'h4E800420, 5'b00010, 64'h800, 32'h0, 64'h0, 64'h1237, 1'b1, 1'b0, 64'h1234, 64'h0, 64'h1237};
    vecs[11] = '{32'h4BFFFFFC, 5'b10000, 64'h0, 32'h0, 64'h0, 64'h0, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0};
    vecs[12] = '{32'h4200FFF8, 5'b01000, 64'hFFFFFFFFFFFFFFFC, 32'h0, 64'h0, 64'h1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0};
    vecs[13] = '{32'h4200FFF9, 5'b01000, 64'h2000, 32'h0, 64'h0, 64'h1, 1'b0, 1'b0, 64'h2004, 64'h2004, 64'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_taken", 64'(taken), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_nia", nia, 64'd0);
    check("rst_lr", lr, 64'd0);
    check("rst_ctr", ctr, 64'd0);
    check("rst_tar", tar, 64'd0);

    for (int i = 0; i < 14; i++) begin
      spr_write(2'd0, vecs[i].pre_lr);
      spr_write(2'd1, vecs[i].pre_ctr);
      start(vecs[i].instr, vecs[i].flags, vecs[i].cia, vecs[i].cr);
      check($sformatf("v%0d_busy_ready", i), 64'(ready), 64'd0);
      check($sformatf("v%0d_busy_valid", i), 64'(valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_valid", i), 64'(valid), 64'd1);
      check($sformatf("v%0d_ready", i), 64'(ready), 64'd1);
      check($sformatf("v%0d_taken", i), 64'(taken), 64'(vecs[i].exp_taken));
      check($sformatf("v%0d_illegal", i), 64'(illegal), 64'(vecs[i].exp_illegal));
      check($sformatf("v%0d_nia", i), nia, vecs[i].exp_nia);
      check($sformatf("v%0d_lr", i), lr, vecs[i].exp_lr);
      check($sformatf("v%0d_ctr", i), ctr, vecs[i].exp_ctr);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_valid_drop", i), 64'(valid), 64'd0);
    end

    // Reset while EXEC: aborted, no result, CTR cleared
    spr_write(2'd1, 64'd4);
    start(32'h4200FFF8, 5'b01000, 64'h2000, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid", 64'(valid), 64'd0);
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_ctr", ctr, 64'd0);
    check("abort_nia", nia, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("abort_valid_late", 64'(valid), 64'd0);

    // SPR write to CTR collides with bdnz decrement: decrement wins
    spr_write(2'd1, 64'd3);
    start(32'h4200FFF8, 5'b01000, 64'h2000, 32'h0);
    spr_we = 1'b1; spr_sel = 2'd1; spr_wdata = 64'd5;
    @(posedge clk);
    @(negedge clk);
    spr_we = 1'b0;
    check("coll_valid", 64'(valid), 64'd1);
    check("coll_nia", nia, 64'h1FF8);
    check("coll_ctr", ctr, 64'd2);

    // SPR write to LR during a non-linking branch is honoured
    spr_write(2'd0, 64'd0);
    start(32'h48000100, 5'b10000, 64'h1000, 32'h0);
    spr_we = 1'b1; spr_sel = 2'd0; spr_wdata = 64'hABC;
    @(posedge clk);
    @(negedge clk);
    spr_we = 1'b0;
    check("nocoll_lr", lr, 64'hABC);
    check("nocoll_nia", nia, 64'h1100);

`ifdef BRANCH_TAR_EN
    spr_write(2'd2, 64'h4003);
    check("tar_write", tar, 64'h4003);
    start(32'h4E800460, 5'b00001, 64'h900, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("bctar_illegal", 64'(illegal), 64'd0);
    check("bctar_nia", nia, 64'h4000);
`else
    spr_write(2'd2, 64'h4003);
    check("tar_dropped", tar, 64'd0);
    start(32'h4E800460, 5'b00001, 64'h900, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("bctar_illegal", 64'(illegal), 64'd1);
    check("bctar_nia", nia, 64'h904);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
